// File: rtl/bsearch_guesser_pkg.sv
// Shared definitions for the binary-search guesser: FSM state type and
// sizing helpers for the initial midpoint and worst-case step count.
package bsearch_guesser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic int unsigned init_mid(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic int unsigned max_steps(input int unsigned width);
        return width + 32'd1;
    endfunction

    localparam int unsigned DEFAULT_WIDTH     = 4;
    localparam int unsigned DEFAULT_INIT_MID  = init_mid(DEFAULT_WIDTH);
    localparam int unsigned DEFAULT_MAX_STEPS = max_steps(DEFAULT_WIDTH);

endpackage

// File: rtl/bsearch_guesser.sv
// Binary-search initiator: drives operand b of an external magnitude
// comparator and narrows [lo, hi] from its a_big / b_big / equal flags.
module bsearch_guesser
    import bsearch_guesser_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              a_big,
    input  logic              b_big,
    input  logic              equal,
    output logic [WIDTH-1:0]  guess,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              error,
    output logic [WIDTH-1:0]  result,
    output logic [STEP_W-1:0] steps
);

    localparam logic [WIDTH-1:0] INIT_GUESS = WIDTH'(init_mid(WIDTH));

    state_t           state;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             hit;
    logic             go_up;
    logic             go_dn;

    // Sum is taken one bit wider so the midpoint never wraps.
    function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] l,
                                                  input logic [WIDTH-1:0] h);
        logic [WIDTH:0] sum;
        sum = {1'b0, l} + {1'b0, h};
        return sum[WIDTH:1];
    endfunction

    always_comb begin
        hit   = 1'b0;
        go_up = 1'b0;
        go_dn = 1'b0;
        case ({a_big, b_big, equal})
            3'b001:  hit   = 1'b1;
            3'b100:  go_up = (guess != hi);
            3'b010:  go_dn = (guess != lo);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            guess  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            error  <= 1'b0;
            result <= '0;
            steps  <= '0;
            lo     <= '0;
            hi     <= '1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SEARCH;
                        lo    <= '0;
                        hi    <= '1;
                        guess <= INIT_GUESS;
                        steps <= '0;
                        found <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SEARCH: begin
                    steps <= steps + 1'b1;
                    if (hit) begin
                        state  <= FINISH;
                        result <= guess;
                        found  <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (go_up) begin
                        lo    <= guess + 1'b1;
                        guess <= midpoint(guess + 1'b1, hi);
                    end else if (go_dn) begin
                        hi    <= guess - 1'b1;
                        guess <= midpoint(lo, guess - 1'b1);
                    end else begin
                        // Non-one-hot flags or a move past the range bound.
                        state <= FINISH;
                        error <= 1'b1;
                        found <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsearch_guesser.sv
// Directed bench: a behavioural comparator closes the loop around the
// guesser; expected guess sequences are queued and consumed per SEARCH cycle.
module tb_bsearch_guesser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] secret;
    logic       force_en;
    logic [2:0] force_flags;
    logic       a_big, b_big, equal;
    logic [3:0] guess;
    logic       busy, done, found, error;
    logic [3:0] result;
    logic [3:0] steps;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_g[$];

    always #5 clk = ~clk;

    assign a_big = force_en ? force_flags[2] : (secret > guess);
    assign b_big = force_en ? force_flags[1] : (secret < guess);
    assign equal = force_en ? force_flags[0] : (secret == guess);

    bsearch_guesser #(.WIDTH(4), .STEP_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_big  (a_big),
        .b_big  (b_big),
        .equal  (equal),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .error  (error),
        .result (result),
        .steps  (steps)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start, then compares guess against the queue on every busy cycle.
    task automatic run_search(input logic [3:0] sec, input int poke_start,
                              input int poke_rst, output int nbusy, output bit got_done);
        bit ended;
        secret   = sec;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        nbusy    = 0;
        got_done = 1'b0;
        ended    = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                got_done = 1'b1;
                ended    = 1'b1;
                break;
            end
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            if (exp_g.size() > 0) chk("guess_seq", guess, exp_g.pop_front());
            start = (nbusy == poke_start);
            rst   = (nbusy == poke_rst);
            nbusy++;
            @(negedge clk);
            start = 1'b0;
        end
        chk("search_terminated", ended, 1'b1);
    endtask

    int nb;
    bit gd;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        secret      = 4'd0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_guess", guess, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_steps", steps, 0);

        // Secret 7: hit on the first guess.
        exp_g = '{4'd7};
        run_search(4'd7, -1, -1, nb, gd);
        chk("s7_done", gd, 1);
        chk("s7_busy_cycles", nb, 1);
        chk("s7_found", found, 1);
        chk("s7_error", error, 0);
        chk("s7_result", result, 7);
        chk("s7_steps", steps, 1);
        @(negedge clk);
        chk("s7_done_pulse", done, 0);
        chk("s7_idle_busy", busy, 0);
        chk("s7_result_hold", result, 7);

        // Secret 15: upper boundary, worst case WIDTH+1 steps.
        exp_g = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run_search(4'd15, -1, -1, nb, gd);
        chk("s15_done", gd, 1);
        chk("s15_busy_cycles", nb, 5);
        chk("s15_found", found, 1);
        chk("s15_result", result, 15);
        chk("s15_steps", steps, 5);
        @(negedge clk);
        chk("s15_done_pulse", done, 0);
        chk("s15_guess_hold", guess, 15);

        // Secret 0: lower boundary.
        exp_g = '{4'd7, 4'd3, 4'd1, 4'd0};
        run_search(4'd0, -1, -1, nb, gd);
        chk("s0_done", gd, 1);
        chk("s0_busy_cycles", nb, 4);
        chk("s0_found", found, 1);
        chk("s0_error", error, 0);
        chk("s0_result", result, 0);
        chk("s0_steps", steps, 4);
        @(negedge clk);

        // No flag set.
        force_en    = 1'b1;
        force_flags = 3'b000;
        exp_g = '{4'd7};
        run_search(4'd7, -1, -1, nb, gd);
        chk("f000_done", gd, 1);
        chk("f000_error", error, 1);
        chk("f000_found", found, 0);
        chk("f000_steps", steps, 1);
        @(negedge clk);
        chk("f000_error_hold", error, 1);

        // Two flags set.
        force_flags = 3'b110;
        exp_g = '{4'd7};
        run_search(4'd7, -1, -1, nb, gd);
        chk("f110_done", gd, 1);
        chk("f110_error", error, 1);
        chk("f110_found", found, 0);
        chk("f110_steps", steps, 1);
        force_en = 1'b0;
        @(negedge clk);

        // Secret 12 with start re-asserted on the 2nd SEARCH cycle.
        exp_g = '{4'd7, 4'd11, 4'd13, 4'd12};
        run_search(4'd12, 1, -1, nb, gd);
        chk("s12_done", gd, 1);
        chk("s12_busy_cycles", nb, 4);
        chk("s12_found", found, 1);
        chk("s12_error", error, 0);
        chk("s12_result", result, 12);
        chk("s12_steps", steps, 4);
        @(negedge clk);
        chk("s12_no_restart", busy, 0);
        @(negedge clk);
        chk("s12_still_idle", busy, 0);

        // Secret 9 with reset on the 3rd SEARCH cycle.
        exp_g = '{4'd7, 4'd11, 4'd9};
        run_search(4'd9, -1, 2, nb, gd);
        chk("abort_no_done", gd, 0);
        chk("abort_busy_cycles", nb, 3);
        chk("abort_busy", busy, 0);
        chk("abort_guess", guess, 0);
        chk("abort_steps", steps, 0);
        chk("abort_found", found, 0);
        rst = 1'b0;
        exp_g.delete();
        @(negedge clk);
        chk("abort_done_after", done, 0);

        exp_g = '{4'd7, 4'd11, 4'd9};
        run_search(4'd9, -1, -1, nb, gd);
        chk("s9_done", gd, 1);
        chk("s9_busy_cycles", nb, 3);
        chk("s9_found", found, 1);
        chk("s9_result", result, 9);
        chk("s9_steps", steps, 3);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
